hazard_tag_pipeline: RTL

//  Producer side of the hazard/forwarding interface. Carries each instruction's destination tag
//  (Rd, RF write enable, load flag) from ID through EX, MEM and WB, and drives the per-stage
//  EX/MEM/WB tag signals that the forwarding unit compares against ID_Rn/ID_Rm.

---
 rtl/hazard_tag_pipeline_pkg.sv | 23 ++
 rtl/hazard_tag_pipeline_if.sv | 36 +++
 rtl/hazard_tag_pipeline_stage.sv | 37 +++
 rtl/hazard_tag_pipeline.sv | 92 +++++++++
 4 files changed

// File: rtl/hazard_tag_pipeline_pkg.sv
// Shared definitions for the hazard tag pipeline: default widths, the packed
// stage-tag layout {load, rf_en, rd} and the bubble constant.
package hazard_tag_pipeline_pkg;

  localparam int DEFAULT_RD_W  = 4;
  localparam int DEFAULT_CNT_W = 16;

  // Tag field positions are derived from RD_W so every stage agrees on the layout.
  function automatic int tagRfEnPos(input int rdW);
    return rdW;
  endfunction

  function automatic int tagLoadPos(input int rdW);
    return rdW + 1;
  endfunction

  function automatic int tagWidth(input int rdW, input bit withLoad);
    return withLoad ? rdW + 2 : rdW + 1;
  endfunction

  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/hazard_tag_pipeline_if.sv
// Bus between the tag pipeline (master, producer of stage tags) and the
// ID/forwarding side (slave).
interface hazard_tag_pipeline_if #(
  parameter int RD_W  = 4,
  parameter int CNT_W = 16
);
  logic [RD_W-1:0]  id_rd;
  logic             id_rf_enable;
  logic             id_load_instr;
  logic             Nop_insertion_S;
  logic             flush;
  logic             mem_stall;

  logic [RD_W-1:0]  EX_Rd;
  logic [RD_W-1:0]  MEM_Rd;
  logic [RD_W-1:0]  WB_Rd;
  logic             EX_RF_enable;
  logic             MEM_RF_enable;
  logic             WB_RF_enable;
  logic             EX_load_instr;
  logic [CNT_W-1:0] load_stall_count;
  logic             flush_pending;

  modport master (
    input  id_rd, id_rf_enable, id_load_instr, Nop_insertion_S, flush, mem_stall,
    output EX_Rd, MEM_Rd, WB_Rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
           EX_load_instr, load_stall_count, flush_pending
  );

  modport slave (
    output id_rd, id_rf_enable, id_load_instr, Nop_insertion_S, flush, mem_stall,
    input  EX_Rd, MEM_Rd, WB_Rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
           EX_load_instr, load_stall_count, flush_pending
  );

endinterface

// File: rtl/hazard_tag_pipeline_stage.sv
// One packed stage-tag register: hold keeps the current tag, load_bubble
// inserts an all-zero tag, otherwise the upstream tag is captured.
module hazard_tag_pipeline_stage
  import hazard_tag_pipeline_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold_i,
  input  logic         load_bubble_i,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);

  logic [W-1:0] tag_d;
  logic [W-1:0] tag_q;

  // Hold wins over bubble so a frozen stage never loses its instruction.
  always_comb begin
    tag_d = tag_q;
    if (!hold_i) begin
      tag_d = load_bubble_i ? {W{BUBBLE_BIT}} : tag_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= {W{BUBBLE_BIT}};
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/hazard_tag_pipeline.sv
// Carries destination tags ID->EX->MEM->WB for the forwarding unit, turning
// Nop_insertion_S, flush and mem_stall into bubbles/freezes and counting load-use stalls.
module hazard_tag_pipeline
  import hazard_tag_pipeline_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int RD_W  = DEFAULT_RD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_tag_pipeline_if.master bus
);

  localparam int EX_W   = tagWidth(RD_W, 1'b1);
  localparam int MW_W   = tagWidth(RD_W, 1'b0);
  localparam int RF_POS = tagRfEnPos(RD_W);
  localparam int LD_POS = tagLoadPos(RD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [EX_W-1:0]  id_tag;
  logic [EX_W-1:0]  ex_tag;
  logic [MW_W-1:0]  mem_tag;
  logic [MW_W-1:0]  wb_tag;
  logic             ex_bubble;
  logic             flush_pending_d;
  logic             flush_pending_q;
  logic [CNT_W-1:0] load_stall_count_d;
  logic [CNT_W-1:0] load_stall_count_q;

  assign id_tag    = {bus.id_load_instr, bus.id_rf_enable, bus.id_rd};
  assign ex_bubble = bus.flush | flush_pending_q | ~bus.Nop_insertion_S;

  hazard_tag_pipeline_stage #(.W(EX_W)) u_ex (
    .clk           (clk),
    .reset         (reset),
    .hold_i        (bus.mem_stall),
    .load_bubble_i (ex_bubble),
    .tag_i         (id_tag),
    .tag_o         (ex_tag)
  );

  // MEM drops the load flag; nothing downstream of EX needs it.
  hazard_tag_pipeline_stage #(.W(MW_W)) u_mem (
    .clk           (clk),
    .reset         (reset),
    .hold_i        (bus.mem_stall),
    .load_bubble_i (1'b0),
    .tag_i         (ex_tag[MW_W-1:0]),
    .tag_o         (mem_tag)
  );

  // WB takes a bubble during a freeze so the held MEM entry retires only once.
  hazard_tag_pipeline_stage #(.W(MW_W)) u_wb (
    .clk           (clk),
    .reset         (reset),
    .hold_i        (1'b0),
    .load_bubble_i (bus.mem_stall),
    .tag_i         (mem_tag),
    .tag_o         (wb_tag)
  );

  always_comb begin
    flush_pending_d    = 1'b0;
    load_stall_count_d = load_stall_count_q;
    if (bus.mem_stall) begin
      flush_pending_d = flush_pending_q | bus.flush;
    end else if (!bus.Nop_insertion_S && load_stall_count_q != CNT_MAX) begin
      load_stall_count_d = load_stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pending_q    <= 1'b0;
      load_stall_count_q <= '0;
    end else begin
      flush_pending_q    <= flush_pending_d;
      load_stall_count_q <= load_stall_count_d;
    end
  end

  assign bus.EX_Rd            = ex_tag[RD_W-1:0];
  assign bus.EX_RF_enable     = ex_tag[RF_POS];
  assign bus.EX_load_instr    = ex_tag[LD_POS];
  assign bus.MEM_Rd           = mem_tag[RD_W-1:0];
  assign bus.MEM_RF_enable    = mem_tag[RF_POS];
  assign bus.WB_Rd            = wb_tag[RD_W-1:0];
  assign bus.WB_RF_enable     = wb_tag[RF_POS];
  assign bus.load_stall_count = load_stall_count_q;
  assign bus.flush_pending    = flush_pending_q;

endmodule
